// File: rtl/case_6_mul_share_arb.sv
// rtl/case_6_mul_share_arb.sv - round-robin arbiter sharing one signed multiplier among requesters
//
// Purpose: grants at most one requester per cycle and registers its operand
// pair onto the shared combinational multiplier. It then carries the product
// and the requester id through NUM_STAGE result registers to a single response
// channel that supports backpressure.
//
// Ports:
//   ap_clk, ap_rst          clock, asynchronous active-high reset
//   req_valid / req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_din0 / req_din1     flattened operands, requester i at [i*W +: W]
//   mul_din0 / mul_din1     registered operands to the shared multiplier
//   mul_dout                multiplier result (combinational from mul_din*)
//   rsp_valid / rsp_ready   response handshake
//   rsp_id / rsp_dout       originating requester and product
//   inflight                accepted operations not yet returned
module case_6_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DIN0_WIDTH = 5,
    parameter int DIN1_WIDTH = 5,
    parameter int DOUT_WIDTH = 6,
    parameter int NUM_STAGE  = 2
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
    output logic [DIN0_WIDTH-1:0]            mul_din0,
    output logic [DIN1_WIDTH-1:0]            mul_din1,
    input  logic [DOUT_WIDTH-1:0]            mul_dout,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_WIDTH-1:0]              rsp_id,
    output logic [DOUT_WIDTH-1:0]            rsp_dout,
    output logic [$clog2(NUM_STAGE+2)-1:0]   inflight
);

    localparam int CW = $clog2(NUM_STAGE + 2);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    logic [ID_WIDTH-1:0]   ptr;
    logic                  stall;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   gid;
    logic                  any;
    logic                  req_hs;
    logic                  rsp_hs;
    int                    idx;

    logic                  valid0;
    logic [ID_WIDTH-1:0]   id0;
    logic [NUM_STAGE-1:0]  st_valid;
    logic [ID_WIDTH-1:0]   st_id   [NUM_STAGE];
    logic [DOUT_WIDTH-1:0] st_dout [NUM_STAGE];

    // The whole pipe freezes while the response is blocked, so nothing can be accepted.
    assign stall  = rsp_valid & ~rsp_ready;
    assign req_hs = any & ~stall;
    assign rsp_hs = rsp_valid & rsp_ready;

    // Search from the pointer upward with wrap; the first valid requester wins.
    always_comb begin
        grant = '0;
        gid   = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req_valid[idx]) begin
                any        = 1'b1;
                gid        = idx[ID_WIDTH-1:0];
                grant[idx] = 1'b1;
            end
        end
    end

    // Grants are masked during reset so that req_ready reads zero while ap_rst is high.
    assign req_ready = (stall || ap_rst) ? '0 : grant;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr      <= '0;
            valid0   <= 1'b0;
            id0      <= '0;
            mul_din0 <= '0;
            mul_din1 <= '0;
            st_valid <= '0;
            for (int s = 0; s < NUM_STAGE; s++) begin
                st_id[s]   <= '0;
                st_dout[s] <= '0;
            end
        end else if (!stall) begin
            valid0 <= req_hs;
            if (req_hs) begin
                // Operands are only loaded on a handshake so the multiplier inputs stay quiet otherwise.
                mul_din0 <= req_din0[gid*DIN0_WIDTH +: DIN0_WIDTH];
                mul_din1 <= req_din1[gid*DIN1_WIDTH +: DIN1_WIDTH];
                id0      <= gid;
                ptr      <= (gid == LAST_ID) ? '0 : gid + ID_WIDTH'(1);
            end
            st_valid[0] <= valid0;
            st_id[0]    <= id0;
            st_dout[0]  <= mul_dout;
            for (int s = 1; s < NUM_STAGE; s++) begin
                st_valid[s] <= st_valid[s-1];
                st_id[s]    <= st_id[s-1];
                st_dout[s]  <= st_dout[s-1];
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            inflight <= '0;
        end else if (req_hs && !rsp_hs) begin
            inflight <= inflight + CW'(1);
        end else if (!req_hs && rsp_hs) begin
            inflight <= inflight - CW'(1);
        end
    end

    assign rsp_valid = st_valid[NUM_STAGE-1];
    assign rsp_id    = st_id[NUM_STAGE-1];
    assign rsp_dout  = st_dout[NUM_STAGE-1];

endmodule

// File: doc/case_6_mul_share_arb.md
Name: case_6_mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one signed multiplier instance (case_6_mul_5s_5s_6_1_1 style, combinational, instantiated alongside by the integrator) among NUM_REQ requesters.
- Accepts at most one operand pair per cycle and registers it onto the multiplier inputs.
- Carries the product and the requester ID through a NUM_STAGE-deep result pipeline and returns it on a single response channel with backpressure.
- Sits between HLS-generated loop bodies and the shared multiplier.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of rsp_id; must be >= clog2(NUM_REQ)
DIN0_WIDTH, 5, signed operand A width
DIN1_WIDTH, 5, signed operand B width
DOUT_WIDTH, 6, product width returned by the multiplier (LSB-truncated two's complement)
NUM_STAGE, 2, result register stages after the multiplier (>=1)

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept
req_din0  in  NUM_REQ*DIN0_WIDTH  flattened operand A; requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH]
req_din1  in  NUM_REQ*DIN1_WIDTH  flattened operand B, same packing
mul_din0  out  DIN0_WIDTH  registered operand A to shared multiplier
mul_din1  out  DIN1_WIDTH  registered operand B to shared multiplier
mul_dout  in  DOUT_WIDTH  multiplier result, combinational from mul_din0/mul_din1
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_WIDTH  index of originating requester
rsp_dout  out  DOUT_WIDTH  product
inflight  out  clog2(NUM_STAGE+2)  number of accepted, not-yet-returned operations

Behaviour:
- Reset (async assert, sync release):
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_dout=0, mul_din0=0, mul_din1=0, inflight=0.
  - RR pointer=0. All valid bits cleared; in-flight operations are discarded, never returned.
- Stall:
  - stall = rsp_valid & ~rsp_ready.
  - While stalled, operand register, all result stages and the pointer hold, and req_ready is all-zero.
- Arbitration:
  - When not stalled, grant the first i with req_valid[i]=1, searching from the pointer upward with wrap.
  - req_ready is one-hot or zero, combinational from req_valid, pointer and stall.
  - Handshake on requester i = req_valid[i] & req_ready[i]. Non-granted requesters hold valid and data; no request is ever dropped.
  - After a handshake on requester i, pointer <= (i+1) mod NUM_REQ. With no handshake, pointer holds.
- Pipeline, handshake in cycle c:
  - Edge ending c: operand register <= granted req_din0/din1, valid0 <= 1, id0 <= i.
  - Cycle c+1: mul_din0/mul_din1 drive the multiplier.
  - Edge ending c+1: stage1 <= {valid0, id0, mul_dout}.
  - Each following edge advances one stage; the last stage drives rsp_*.
  - rsp_valid rises in cycle c+NUM_STAGE+1. With defaults, the response appears 3 cycles after the handshake cycle.
  - No handshake: valid0 <= 0 and mul_din* hold their old values (no toggling).
- Throughput:
  - 1 op/cycle when rsp_ready=1 and any requester is valid.
  - Bubbles are not compressed; during a stall the whole pipe freezes.
- Response:
  - rsp_id/rsp_dout stay stable while rsp_valid=1 and rsp_ready=0.
  - Response consumed on rsp_valid & rsp_ready.
- inflight: +1 per request handshake, -1 per response handshake, both in the same cycle = unchanged. Max NUM_STAGE+1.
- Width: the block does not compute. rsp_dout equals mul_dout as sampled, i.e. the DOUT_WIDTH LSBs of the signed product.
- Ordering: responses return in acceptance order.

Test Plan:
- Reset then single op: req 1 sends din0=-3 (0x1D), din1=5 at cycle 0, rsp_ready=1 -> req_ready[1]=1 in cycle 0; cycle 3: rsp_valid=1, rsp_id=1, rsp_dout=0x31 (-15); inflight 1 during cycles 1-3, then 0.
- All 4 requesters valid continuously, rsp_ready=1 -> grants rotate 0,1,2,3,0,...; one response per cycle from cycle 3 with ids in the same order.
- Backpressure: 3 back-to-back ops (3*-4=0x34, 2*2=0x04, -1*-1=0x01), rsp_ready=0 cycles 3-6 -> rsp_dout=0x34 held cycles 3-6 and req_ready=0 throughout; on release, 0x34, 0x04, 0x01 return on consecutive cycles with nothing lost.
- Pointer fairness: only req 2 is valid for 2 ops, then req 0 and req 3 assert together -> req 3 is granted first (pointer=3), then req 0.
- Async reset mid-flight: assert ap_rst between clock edges with 2 ops in flight -> rsp_valid=0 and inflight=0 immediately; no response after release; next grant starts from requester 0.
- Overflow truncation: din0=-16, din1=-16 (product 256) -> rsp_dout=0x00; din0=15, din1=15 (225) -> rsp_dout=0x21.
